// File: rtl/usb_buf_pkg.sv
// Shared types and default sizing for the USB endpoint buffer arbiter.
package usb_buf_pkg;

   localparam int BUF_DEPTH        = 64;
   localparam int BUF_ADDR_W       = 6;
   localparam int BUF_DATA_W       = 8;
   localparam int BUF_STARVE_LIMIT = 4;

   typedef enum logic [2:0] {
      REQ_RX_STORE,
      REQ_TX_GET,
      REQ_AHB_STORE,
      REQ_AHB_GET,
      REQ_NONE
   } req_e;

   typedef enum logic {
      RUN,
      FLUSH
   } state_e;

endpackage

// File: rtl/usb_buf_starve_ctr.sv
// Counts consecutive denied cycles of one pending requester; flags saturation.
module usb_buf_starve_ctr
   import usb_buf_pkg::*;
#(
   parameter int LIMIT = BUF_STARVE_LIMIT
) (
   input  logic clk,
   input  logic n_rst,
   input  logic req,
   input  logic gnt,
   output logic sat
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (!req || gnt) begin
         cnt <= '0;
      end else if (cnt != CW'(LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == CW'(LIMIT));

endmodule

// File: rtl/usb_buffer_arbiter.sv
// Single-port endpoint buffer scheduler: one RAM access per cycle, USB-first
// priority with starvation promotion for the AHB side, FIFO pointers and occupancy.
module usb_buffer_arbiter
   import usb_buf_pkg::*;
#(
   parameter int DEPTH        = BUF_DEPTH,
   parameter int ADDR_W       = BUF_ADDR_W,
   parameter int DATA_W       = BUF_DATA_W,
   parameter int STARVE_LIMIT = BUF_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic              rx_store_req,
   input  logic [DATA_W-1:0] rx_store_data,
   input  logic              tx_get_req,
   input  logic              ahb_store_req,
   input  logic [DATA_W-1:0] ahb_store_data,
   input  logic              ahb_get_req,
   output logic              rx_store_gnt,
   output logic              tx_get_gnt,
   output logic              ahb_store_gnt,
   output logic              ahb_get_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_owner,
   output logic [ADDR_W:0]   buffer_occupancy,
   output logic              overflow,
   output logic              underflow,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wen,
   output logic              ram_ren,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_e            state, state_nx;
   req_e              sel;
   logic [ADDR_W-1:0] wptr, rptr;
   logic [ADDR_W:0]   occ;
   logic              store_sat, get_sat;
   logic              run, full, empty, is_wr, is_rd, wr_go, rd_go;
   logic              rd_valid_q, rd_zero_q, rd_owner_q;

   usb_buf_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_store_starve (
      .clk   (clk),
      .n_rst (n_rst),
      .req   (ahb_store_req),
      .gnt   (ahb_store_gnt),
      .sat   (store_sat)
   );

   usb_buf_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_get_starve (
      .clk   (clk),
      .n_rst (n_rst),
      .req   (ahb_get_req),
      .gnt   (ahb_get_gnt),
      .sat   (get_sat)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= RUN;
      else        state <= state_nx;
   end

   // A clear wins over every request in the cycle it is seen, in either state.
   always_comb begin
      state_nx = clear ? FLUSH : RUN;
      run      = n_rst && (state == RUN) && !clear;
      sel      = REQ_NONE;
      if (run) begin
         if (ahb_store_req && store_sat)    sel = REQ_AHB_STORE;
         else if (ahb_get_req && get_sat)   sel = REQ_AHB_GET;
         else if (rx_store_req)             sel = REQ_RX_STORE;
         else if (tx_get_req)               sel = REQ_TX_GET;
         else if (ahb_store_req)            sel = REQ_AHB_STORE;
         else if (ahb_get_req)              sel = REQ_AHB_GET;
      end
   end

   assign rx_store_gnt  = (sel == REQ_RX_STORE);
   assign tx_get_gnt    = (sel == REQ_TX_GET);
   assign ahb_store_gnt = (sel == REQ_AHB_STORE);
   assign ahb_get_gnt   = (sel == REQ_AHB_GET);

   assign is_wr = rx_store_gnt || ahb_store_gnt;
   assign is_rd = tx_get_gnt || ahb_get_gnt;
   assign full  = (occ == (ADDR_W+1)'(DEPTH));
   assign empty = (occ == '0);
   assign wr_go = is_wr && !full;
   assign rd_go = is_rd && !empty;

   assign ram_wen   = wr_go;
   assign ram_ren   = rd_go;
   assign ram_addr  = wr_go ? wptr : (rd_go ? rptr : '0);
   assign ram_wdata = wr_go ? (rx_store_gnt ? rx_store_data : ahb_store_data) : '0;
   assign overflow  = is_wr && full;
   assign underflow = is_rd && empty;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr       <= '0;
         rptr       <= '0;
         occ        <= '0;
         rd_valid_q <= 1'b0;
         rd_zero_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         if (state == FLUSH) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
         end else if (wr_go) begin
            wptr <= wptr + 1'b1;
            occ  <= occ + 1'b1;
         end else if (rd_go) begin
            rptr <= rptr + 1'b1;
            occ  <= occ - 1'b1;
         end
         rd_valid_q <= is_rd;
         rd_zero_q  <= is_rd && empty;
         if (is_rd) rd_owner_q <= ahb_get_gnt;
      end
   end

   // An empty read still completes, returning zero instead of stale RAM output.
   assign rd_valid         = rd_valid_q;
   assign rd_data          = (rd_valid_q && !rd_zero_q) ? ram_rdata : '0;
   assign rd_owner         = rd_owner_q;
   assign buffer_occupancy = occ;

endmodule
